conv_accum_bin: RTL and testbench

- Downstream neighbour of the bit-serial convolution stage; consumes its signed 5-bit per-pixel results (dout/ovalid/done).
- Accumulates partial sums per output pixel across input-channel passes and compares the final sum against a folded batch-norm threshold.
- Emits one binarized activation bit per pixel through a small valid/ready output FIFO to the next layer's input buffer.

---
 rtl/conv_accum_bin_if.sv | 30 +++
 rtl/conv_accum_bin.sv | 146 ++++++++++++++
 tb/tb_conv_accum_bin.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_accum_bin_if.sv
// conv_accum_bin_if: the pixel stream into the accumulator and the binarized
// bit stream out of it, bundled as one interface.
// slave  : the accumulator side (consumes din/ivalid/idone, drives bout/bvalid)
// master : the surrounding side (conv stage plus next-layer input buffer)
interface conv_accum_bin_if;
    logic signed [4:0] din;
    logic              ivalid;
    logic              idone;
    logic              bout;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  din,
        input  ivalid,
        input  idone,
        input  bready,
        output bout,
        output bvalid
    );

    modport master (
        output din,
        output ivalid,
        output idone,
        output bready,
        input  bout,
        input  bvalid
    );
endinterface

// File: rtl/conv_accum_bin.sv
// conv_accum_bin: accumulates per-pixel conv results across input-channel
// passes, compares the final sum with a folded batch-norm threshold and
// queues one activation bit per pixel in a small output FIFO.
// Build option: define ACC_SAT_EN to make partial-sum adds saturate;
// otherwise they wrap at PSUM_W bits.
module conv_accum_bin #(
    parameter int MAX_PIX    = 128,
    parameter int PSUM_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cfg_load,
    input  logic [7:0]               cfg_num_ch,
    input  logic signed [PSUM_W-1:0] cfg_thresh,
    conv_accum_bin_if.slave          bus,
    output logic                     layer_done,
    output logic                     ovf_err
);
    localparam int DATA_W = 5;
    localparam int IDX_W  = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
    localparam int CNT_W  = $clog2(MAX_PIX + 1);
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Partial-sum add; result is clamped or wrapped to PSUM_W bits.
    function automatic logic signed [PSUM_W-1:0] acc_add(
        input logic signed [PSUM_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
`ifdef ACC_SAT_EN
        logic signed [PSUM_W:0] wide;
        wide = (PSUM_W+1)'(a) + (PSUM_W+1)'(b);
        if (wide[PSUM_W] != wide[PSUM_W-1])
            return wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                : {1'b0, {(PSUM_W-1){1'b1}}};
        return wide[PSUM_W-1:0];
`else
        return a + PSUM_W'(b);
`endif
    endfunction

    logic [CNT_W-1:0]         pix_cnt;
    logic [7:0]               ch_cnt;
    logic [7:0]               num_ch;
    logic signed [PSUM_W-1:0] thresh;

    logic signed [PSUM_W-1:0] psum_mem [MAX_PIX];

    logic                     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              fifo_cnt;

    logic                     idle;
    logic                     last_pass;
    logic                     accept;
    logic [IDX_W-1:0]         idx;
    logic signed [PSUM_W-1:0] din_ext;
    logic signed [PSUM_W-1:0] sum_p0;
    logic                     bit_p0;
    logic                     vld_p0;
    logic                     full;
    logic                     pop;
    logic                     push_ok;

    assign idle      = (ch_cnt == 8'd0) && (pix_cnt == '0);
    assign last_pass = (ch_cnt == num_ch - 8'd1);
    assign accept    = bus.ivalid && (pix_cnt != CNT_W'(MAX_PIX));
    assign idx       = pix_cnt[IDX_W-1:0];
    assign din_ext   = PSUM_W'(bus.din);

    // Stage p0: running sum for the current pixel and its compare bit
    assign sum_p0  = (ch_cnt == 8'd0) ? din_ext : acc_add(psum_mem[idx], bus.din);
    assign bit_p0  = (sum_p0 >= thresh);
    assign vld_p0  = accept && last_pass;

    assign full    = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign pop     = bus.bvalid && bus.bready;
    assign push_ok = vld_p0 && (!full || pop);

    assign bus.bvalid = (fifo_cnt != '0);
    assign bus.bout   = bus.bvalid && fifo_mem[rd_ptr];

    // Store partial sums for every pass except the last one
    always_ff @(posedge clk) begin
        if (accept && !last_pass)
            psum_mem[idx] <= sum_p0;
    end

    // Write the compare bit into the output FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= bit_p0;
    end

    // Pixel/channel counters, FIFO pointers, config and status flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pix_cnt    <= '0;
            ch_cnt     <= 8'd0;
            num_ch     <= 8'd1;
            thresh     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            layer_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            layer_done <= 1'b0;

            if (accept)
                pix_cnt <= pix_cnt + 1'b1;
            else if (bus.ivalid)
                ovf_err <= 1'b1;

            if (vld_p0 && full && !pop)
                ovf_err <= 1'b1;

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push_ok)
                fifo_cnt <= fifo_cnt - 1'b1;

            // A sample arriving with idone has already been counted above;
            // the pass boundary then resets the pixel index.
            if (bus.idone) begin
                pix_cnt <= '0;
                if (last_pass) begin
                    ch_cnt     <= 8'd0;
                    layer_done <= 1'b1;
                end else begin
                    ch_cnt <= ch_cnt + 8'd1;
                end
            end

            if (cfg_load && idle) begin
                num_ch <= (cfg_num_ch == 8'd0) ? 8'd1 : cfg_num_ch;
                thresh <= cfg_thresh;
            end
        end
    end
endmodule

// File: tb/tb_conv_accum_bin.sv
// tb_conv_accum_bin: directed scenarios plus randomized traffic for
// conv_accum_bin, checked every cycle against an integer/queue model.
module tb_conv_accum_bin;
    localparam int MAX_PIX = 8;
    localparam int PSUM_W  = 6;
    localparam int DEPTH   = 4;
    localparam int P_HI    = 2**(PSUM_W-1) - 1;
    localparam int P_LO    = -(2**(PSUM_W-1));

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     cfg_load = 1'b0;
    logic [7:0]               cfg_num_ch = 8'd0;
    logic signed [PSUM_W-1:0] cfg_thresh = '0;
    logic                     layer_done;
    logic                     ovf_err;

    conv_accum_bin_if bif ();

    conv_accum_bin #(
        .MAX_PIX(MAX_PIX),
        .PSUM_W(PSUM_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_load(cfg_load),
        .cfg_num_ch(cfg_num_ch),
        .cfg_thresh(cfg_thresh),
        .bus(bif),
        .layer_done(layer_done),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int ld_cnt = 0;

    // reference model state
    int m_pix, m_ch, m_num, m_thr;
    int m_psum [MAX_PIX];
    bit m_ovf, m_ld;
    bit mq [$];
    bit obs [$];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef ACC_SAT_EN
        if (s > P_HI) s = P_HI;
        if (s < P_LO) s = P_LO;
`else
        s = ((s - P_LO) % (2**PSUM_W) + (2**PSUM_W)) % (2**PSUM_W) + P_LO;
`endif
        return s;
    endfunction

    // One clock: record accepted bits, advance the model, clock, compare.
    task automatic step();
        bit pre_pop, pre_last, pre_idle, push, pbit;
        int p;
        push = 0;
        pbit = 0;
        if (rstn && bif.bvalid && bif.bready) obs.push_back(bif.bout);
        if (!rstn) begin
            m_pix = 0; m_ch = 0; m_num = 1; m_thr = 0;
            m_ovf = 0; m_ld = 0;
            mq.delete();
        end else begin
            pre_pop  = (mq.size() > 0) && bif.bready;
            pre_last = (m_ch == m_num - 1);
            pre_idle = (m_ch == 0) && (m_pix == 0);
            if (bif.ivalid) begin
                if (m_pix == MAX_PIX) begin
                    m_ovf = 1;
                end else begin
                    if (m_ch == 0) p = int'(bif.din);
                    else           p = m_add(m_psum[m_pix], int'(bif.din));
                    if (pre_last) begin
                        push = 1;
                        pbit = (p >= m_thr);
                    end else begin
                        m_psum[m_pix] = p;
                    end
                    m_pix++;
                end
            end
            if (pre_pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(pbit);
                else m_ovf = 1;
            end
            m_ld = 0;
            if (bif.idone) begin
                m_pix = 0;
                if (pre_last) begin m_ch = 0; m_ld = 1; end
                else m_ch++;
            end
            if (cfg_load && pre_idle) begin
                m_num = (cfg_num_ch == 0) ? 1 : int'(cfg_num_ch);
                m_thr = int'(cfg_thresh);
            end
        end
        @(posedge clk);
        #1;
        check("bvalid", bif.bvalid, mq.size() > 0);
        if (mq.size() > 0) check("bout", bif.bout, mq[0]);
        check("layer_done", layer_done, m_ld);
        check("ovf_err", ovf_err, m_ovf);
        if (layer_done) ld_cnt++;
    endtask

    task automatic cyc(input bit iv, input int d, input bit dn);
        bif.ivalid = iv;
        bif.din    = 5'(d);
        bif.idone  = dn;
        step();
        bif.ivalid = 1'b0;
        bif.idone  = 1'b0;
    endtask

    task automatic set_cfg(input int n, input int t);
        cfg_load   = 1'b1;
        cfg_num_ch = 8'(n);
        cfg_thresh = PSUM_W'(t);
        step();
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        check("rst_bvalid", bif.bvalid, 0);
        check("rst_bout", bif.bout, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_ovf", ovf_err, 0);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    // Compare drained bits with an LSB-first expected mask.
    task automatic check_obs(input string tag, input int n, input int mask);
        check({tag, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++)
            check({tag, "_bit"}, obs[i], (mask >> i) & 1);
    endtask

    initial begin
        bif.din = '0; bif.ivalid = 0; bif.idone = 0; bif.bready = 1;
        do_reset();

        // single channel, thresh 0
        set_cfg(1, 0);
        obs.delete(); ld_cnt = 0;
        cyc(1, 3, 0); cyc(1, -1, 0); cyc(1, 0, 0); cyc(1, -16, 0);
        cyc(0, 0, 1);
        idle_steps(4);
        check_obs("t1", 4, 5);
        check("t1_ld_pulses", ld_cnt, 1);
        check("t1_ovf", ovf_err, 0);

        // three channels, thresh 5, sums 5 and 4
        set_cfg(3, 5);
        obs.delete(); ld_cnt = 0;
        cyc(1, 2, 0); cyc(1, 2, 0); cyc(0, 0, 1);
        cyc(1, 2, 0); cyc(1, 2, 0); cyc(0, 0, 1);
        check("t2_ld_early", ld_cnt, 0);
        cyc(1, 1, 0); cyc(1, 0, 1);
        idle_steps(4);
        check_obs("t2", 2, 1);
        check("t2_ld_pulses", ld_cnt, 1);

        // back-pressure: FIFO fills, two bits dropped
        set_cfg(1, 0);
        obs.delete();
        bif.bready = 0;
        cyc(1, 5, 0); cyc(1, -2, 0); cyc(1, -3, 0);
        cyc(1, 4, 0); cyc(1, 7, 0); cyc(1, 7, 1);
        check("t3_ovf", ovf_err, 1);
        bif.bready = 1;
        idle_steps(8);
        check_obs("t3", 4, 9);
        do_reset();

        // four passes of 15 against thresh 31: saturate vs wrap
        set_cfg(4, 31);
        obs.delete();
        for (int c = 0; c < 4; c++) begin
            cyc(1, 15, 0);
            cyc(0, 0, 1);
        end
        idle_steps(3);
`ifdef ACC_SAT_EN
        check_obs("t4", 1, 1);
`else
        check_obs("t4", 1, 0);
`endif

        // cfg_load mid-pass ignored, idle load applies to next layer
        set_cfg(1, 0);
        obs.delete();
        cyc(1, 5, 0);
        set_cfg(1, 9);
        cyc(1, 5, 0);
        cyc(1, 5, 1);
        set_cfg(1, 9);
        cyc(1, 5, 0);
        cyc(1, 9, 1);
        idle_steps(4);
        check_obs("t5", 5, 23);

        // reset mid-pass aborts the layer
        set_cfg(2, 0);
        obs.delete();
        cyc(1, 3, 0); cyc(1, 4, 0);
        do_reset();
        cyc(1, 2, 0); cyc(1, -1, 1);
        idle_steps(3);
        check_obs("t6", 2, 1);

        // more samples than MAX_PIX in one pass
        do_reset();
        set_cfg(1, 0);
        obs.delete();
        for (int i = 0; i < MAX_PIX + 1; i++) cyc(1, 1, 0);
        cyc(0, 0, 1);
        idle_steps(4);
        check_obs("t7", MAX_PIX, 255);
        check("t7_ovf", ovf_err, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rstn         = ($urandom_range(0, 599) != 0);
            cfg_load     = ($urandom_range(0, 9) == 0);
            cfg_num_ch   = 8'($urandom_range(0, 4));
            cfg_thresh   = PSUM_W'($urandom_range(0, 63));
            bif.ivalid   = ($urandom_range(0, 9) < 6);
            bif.din      = 5'($urandom_range(0, 31));
            bif.idone    = ($urandom_range(0, 5) == 0);
            bif.bready   = ($urandom_range(0, 9) < 7);
            step();
        end
        rstn = 1; cfg_load = 0; bif.ivalid = 0; bif.idone = 0; bif.bready = 1;
        idle_steps(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
